// File: rtl/dbgdump.sv
// Debug dump sequencer: walks the debug read mux (registers, data words, PC)
// and streams each read result out as one 32-bit word over valid/ready.
module dbgdump #(
  parameter int NREGS = 32,
  parameter int NDATA = 32,
  parameter int RDLAT = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        abort,
  output logic [6:0]  dbgsel,
  output logic        dbgreaden,
  input  logic [31:0] dbgin,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {S_IDLE, S_SEL, S_WAIT, S_EMIT, S_DONE} state_t;
  typedef enum logic [1:0] {PH_REG, PH_DATA, PH_PC} phase_t;

  localparam logic [4:0] LAST_REG  = 5'(NREGS - 1);
  localparam logic [4:0] LAST_DATA = (NDATA > 0) ? 5'(NDATA - 1) : 5'd0;
  localparam logic [2:0] LAT       = 3'(RDLAT);

  state_t      state_reg, state_next;
  phase_t      phase_reg, phase_next;
  logic [4:0]  idx_reg, idx_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic [31:0] data_reg, data_next;
  logic [6:0]  sel_reg, sel_next;
  logic        readen_reg, valid_reg, busy_reg, done_reg;
  logic        active;

  assign active = (state_reg == S_SEL) || (state_reg == S_WAIT) || (state_reg == S_EMIT);

  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    data_next  = data_reg;
    case (state_reg)
      S_IDLE: begin
        if (start && !abort) begin
          state_next = S_SEL;
          phase_next = PH_REG;
          idx_next   = 5'd0;
        end
      end
      S_SEL: begin
        cnt_next   = LAT;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        cnt_next = cnt_reg - 3'd1;
        if (cnt_reg == 3'd1) begin
          data_next  = dbgin;
          state_next = S_EMIT;
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          if (phase_reg == PH_PC) begin
            state_next = S_DONE;
          end else begin
            state_next = S_SEL;
            // Phase boundaries are exact indices; the 5-bit index never wraps.
            if (phase_reg == PH_REG && idx_reg == LAST_REG) begin
              phase_next = (NDATA > 0) ? PH_DATA : PH_PC;
              idx_next   = 5'd0;
            end else if (phase_reg == PH_DATA && idx_reg == LAST_DATA) begin
              phase_next = PH_PC;
              idx_next   = 5'd0;
            end else begin
              idx_next = idx_reg + 5'd1;
            end
          end
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (abort && active) begin
      state_next = S_IDLE;
      data_next  = data_reg;
    end
  end

  always_comb begin
    sel_next = sel_reg;
    case (phase_next)
      PH_REG:  sel_next = {2'b00, idx_next};
      PH_DATA: sel_next = {2'b01, idx_next};
      PH_PC:   sel_next = 7'b1000000;
      default: sel_next = sel_reg;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg  <= S_IDLE;
      phase_reg  <= PH_REG;
      idx_reg    <= 5'd0;
      cnt_reg    <= 3'd0;
      data_reg   <= 32'd0;
      sel_reg    <= 7'd0;
      readen_reg <= 1'b0;
      valid_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      phase_reg  <= phase_next;
      idx_reg    <= idx_next;
      cnt_reg    <= cnt_next;
      data_reg   <= data_next;
      sel_reg    <= sel_next;
      readen_reg <= (state_next == S_SEL);
      valid_reg  <= (state_next == S_EMIT);
      busy_reg   <= (state_next == S_SEL) || (state_next == S_WAIT) || (state_next == S_EMIT);
      done_reg   <= (state_next == S_DONE);
    end
  end

  assign dbgsel    = sel_reg;
  assign dbgreaden = readen_reg;
  assign out_data  = data_reg;
  assign out_valid = valid_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_dbgdump.sv
// Bench for dbgdump: two instances (default and a small RDLAT=3 build) fed by
// latency-accurate debug mux models and checked against expected dump order.
module tb_dbgdump;

  logic clk;
  logic rstn;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        start0, abort0, rden0, valid0, ready0, busy0, done0;
  logic [6:0]  sel0;
  logic [31:0] din0, data0;
  logic        start1, abort1, rden1, valid1, ready1, busy1, done1;
  logic [6:0]  sel1;
  logic [31:0] din1, data1;
  logic [31:0] salt0 = 32'd0;
  logic [31:0] salt1 = 32'd0;

  int n_tests = 0;
  int n_fail  = 0;

  dbgdump dut0 (
    .clk(clk), .rstn(rstn), .start(start0), .abort(abort0),
    .dbgsel(sel0), .dbgreaden(rden0), .dbgin(din0),
    .out_data(data0), .out_valid(valid0), .out_ready(ready0),
    .busy(busy0), .done(done0)
  );

  dbgdump #(.NREGS(4), .NDATA(0), .RDLAT(3)) dut1 (
    .clk(clk), .rstn(rstn), .start(start1), .abort(abort1),
    .dbgsel(sel1), .dbgreaden(rden1), .dbgin(din1),
    .out_data(data1), .out_valid(valid1), .out_ready(ready1),
    .busy(busy1), .done(done1)
  );

  function automatic logic [31:0] muxval(input logic [6:0] s, input logic [31:0] salt);
    return ({25'd0, s} * 32'd3) ^ salt;
  endfunction

  // Mux models: the read result is present only in the cycle RDLAT after the
  // strobe; every other cycle carries random junk.
  bit         hv0 [0:4];
  logic [6:0] hs0 [0:4];
  bit         hv1 [0:4];
  logic [6:0] hs1 [0:4];

  always @(negedge clk) begin
    hv0[0] <= rden0;
    hs0[0] <= sel0;
    hv1[0] <= rden1;
    hs1[0] <= sel1;
    for (int k = 1; k < 5; k++) begin
      hv0[k] <= hv0[k-1];
      hs0[k] <= hs0[k-1];
      hv1[k] <= hv1[k-1];
      hs1[k] <= hs1[k-1];
    end
    din0 <= hv0[0] ? muxval(hs0[0], salt0) : $urandom;
    din1 <= hv1[2] ? muxval(hs1[2], salt1) : $urandom;
  end

  task automatic test_reset();
    int found;
    rstn = 1'b0;
    #1;
    n_tests++;
    if ({sel0, rden0, data0, valid0, busy0, done0} !== 43'd0) begin
      n_fail++;
      $display("FAIL reset_dut0: got sel=%h rden=%b data=%h valid=%b busy=%b done=%b want all 0",
               sel0, rden0, data0, valid0, busy0, done0);
    end
    n_tests++;
    if ({sel1, rden1, data1, valid1, busy1, done1} !== 43'd0) begin
      n_fail++;
      $display("FAIL reset_dut1: got sel=%h rden=%b data=%h valid=%b busy=%b done=%b want all 0",
               sel1, rden1, data1, valid1, busy1, done1);
    end
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    salt0 = $urandom;
    ready0 = 1'b1;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    found = 0;
    for (int c = 0; c < 300 && found == 0; c++) begin
      if (sel0 == 7'h25 && busy0 && !rden0 && !valid0) found = 1;
      else begin @(posedge clk); #1; end
    end
    n_tests++;
    if (found == 0) begin
      n_fail++;
      $display("FAIL reset_reach_wait: got no WAIT of data word 5 want reached within 300 cycles");
    end
    #2;
    rstn = 1'b0;
    #1;
    n_tests++;
    if ({sel0, rden0, data0, valid0, busy0, done0} !== 43'd0) begin
      n_fail++;
      $display("FAIL reset_async: got sel=%h rden=%b data=%h valid=%b busy=%b done=%b want all 0",
               sel0, rden0, data0, valid0, busy0, done0);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    n_tests++;
    if (!(rden0 && busy0 && sel0 == 7'h00)) begin
      n_fail++;
      $display("FAIL reset_restart: got rden=%b busy=%b sel=%h want rden=1 busy=1 sel=00",
               rden0, busy0, sel0);
    end
    abort0 = 1'b1;
    @(posedge clk); #1;
    abort0 = 1'b0;
    $display("[TB] reset: async reset mid-dump and restart checked");
  endtask

  task automatic test_full_dump(input int ready_pct, input logic [31:0] salt);
    logic [6:0]  exp_sel [$];
    int          words, strobes, dones, done_cyc, cyc;
    logic        prev_stall;
    logic [31:0] prev_data;
    logic [6:0]  prev_sel;
    for (int i = 0; i < 32; i++) exp_sel.push_back(7'(i));
    for (int j = 0; j < 32; j++) exp_sel.push_back(7'(32 + j));
    exp_sel.push_back(7'h40);
    salt0 = salt;
    words = 0; strobes = 0; dones = 0; done_cyc = -1;
    prev_stall = 1'b0; prev_data = 32'd0; prev_sel = 7'd0;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    for (cyc = 1; cyc < 3000 && dones == 0; cyc++) begin
      ready0 = (ready_pct >= 100) ? 1'b1 : ($urandom_range(99) < 32'(ready_pct));
      if (rden0) strobes++;
      if (prev_stall) begin
        n_tests++;
        if (!(valid0 && data0 === prev_data && sel0 === prev_sel)) begin
          n_fail++;
          $display("FAIL dump_stall_stable: got valid=%b data=%h sel=%h want valid=1 data=%h sel=%h",
                   valid0, data0, sel0, prev_data, prev_sel);
        end
      end
      if (valid0 && ready0) begin
        n_tests++;
        if (words >= exp_sel.size()) begin
          n_fail++;
          $display("FAIL dump_extra_word: got word %0d data=%h want at most %0d words",
                   words, data0, exp_sel.size());
        end else if (sel0 !== exp_sel[words] || data0 !== muxval(exp_sel[words], salt)) begin
          n_fail++;
          $display("FAIL dump_word%0d: got sel=%h data=%h want sel=%h data=%h",
                   words, sel0, data0, exp_sel[words], muxval(exp_sel[words], salt));
        end
        words++;
      end
      if (done0) begin
        dones++;
        done_cyc = cyc;
      end
      prev_stall = valid0 && !ready0;
      prev_data  = data0;
      prev_sel   = sel0;
      if (dones == 0) begin @(posedge clk); #1; end
    end
    n_tests++;
    if (dones != 1 || words != 65 || strobes != 65) begin
      n_fail++;
      $display("FAIL dump_counts: got done=%0d words=%0d strobes=%0d want 1 65 65",
               dones, words, strobes);
    end
    if (ready_pct >= 100) begin
      n_tests++;
      if (done_cyc != 196) begin
        n_fail++;
        $display("FAIL dump_length: got done at cycle %0d want 196", done_cyc);
      end
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_tests++;
      if (done0 || busy0 || valid0 || rden0) begin
        n_fail++;
        $display("FAIL dump_after_done: got done=%b busy=%b valid=%b rden=%b want all 0",
                 done0, busy0, valid0, rden0);
      end
    end
    $display("[TB] full_dump ready=%0d%%: words=%0d strobes=%0d done_cycle=%0d",
             ready_pct, words, strobes, done_cyc);
  endtask

  task automatic test_backpressure();
    int          found;
    logic [31:0] held;
    salt0 = $urandom;
    ready0 = 1'b1;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    found = 0;
    for (int c = 0; c < 60 && found == 0; c++) begin
      ready0 = (sel0 != 7'h03);
      if (valid0 && sel0 == 7'h03) found = 1;
      else begin @(posedge clk); #1; end
    end
    held = data0;
    n_tests++;
    if (found == 0 || held !== muxval(7'h03, salt0)) begin
      n_fail++;
      $display("FAIL bp_reg3_word: got found=%0d data=%h want found=1 data=%h",
               found, held, muxval(7'h03, salt0));
    end
    for (int k = 0; k < 7; k++) begin
      ready0 = 1'b0;
      n_tests++;
      if (!valid0 || data0 !== held || sel0 !== 7'h03 || rden0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got valid=%b data=%h sel=%h rden=%b want 1 %h 03 0",
                 k, valid0, data0, sel0, rden0, held);
      end
      @(posedge clk); #1;
    end
    ready0 = 1'b1;
    n_tests++;
    if (!valid0 || data0 !== held || sel0 !== 7'h03) begin
      n_fail++;
      $display("FAIL bp_release: got valid=%b data=%h sel=%h want 1 %h 03", valid0, data0, sel0, held);
    end
    @(posedge clk); #1;
    n_tests++;
    if (!(rden0 && sel0 == 7'h04 && !valid0)) begin
      n_fail++;
      $display("FAIL bp_next_sel: got rden=%b sel=%h valid=%b want rden=1 sel=04 valid=0",
               rden0, sel0, valid0);
    end
    abort0 = 1'b1;
    @(posedge clk); #1;
    abort0 = 1'b0;
    $display("[TB] backpressure: reg3 held 7 cycles data=%h", held);
  endtask

  task automatic test_small_config();
    logic [6:0] exp_sel [$];
    int         words, strobes, dones, sel_cyc, cyc;
    logic       prev_rden;
    exp_sel = '{7'h00, 7'h01, 7'h02, 7'h03, 7'h40};
    salt1 = $urandom;
    ready1 = 1'b1;
    words = 0; strobes = 0; dones = 0; sel_cyc = 0; prev_rden = 1'b0;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (cyc = 1; cyc < 200 && dones == 0; cyc++) begin
      if (rden1) begin
        n_tests++;
        if (prev_rden || strobes >= exp_sel.size() || sel1 !== exp_sel[strobes]) begin
          n_fail++;
          $display("FAIL small_strobe%0d: got sel=%h prev_rden=%b want sel=%h single-cycle strobe",
                   strobes, sel1, prev_rden,
                   (strobes < exp_sel.size()) ? exp_sel[strobes] : 7'h7f);
        end
        strobes++;
        sel_cyc = cyc;
      end
      if (valid1 && ready1) begin
        n_tests++;
        if (words >= exp_sel.size() || sel1 !== exp_sel[words] ||
            data1 !== muxval(exp_sel[words], salt1) || (cyc - sel_cyc + 1) != 5) begin
          n_fail++;
          $display("FAIL small_word%0d: got sel=%h data=%h span=%0d want sel=%h data=%h span=5",
                   words, sel1, data1, cyc - sel_cyc + 1,
                   (words < exp_sel.size()) ? exp_sel[words] : 7'h7f,
                   (words < exp_sel.size()) ? muxval(exp_sel[words], salt1) : 32'h0);
        end
        words++;
      end
      if (done1) dones++;
      prev_rden = rden1;
      if (dones == 0) begin @(posedge clk); #1; end
    end
    n_tests++;
    if (dones != 1 || words != 5 || strobes != 5) begin
      n_fail++;
      $display("FAIL small_counts: got done=%0d words=%0d strobes=%0d want 1 5 5", dones, words, strobes);
    end
    @(posedge clk); #1;
    $display("[TB] small_config: words=%0d strobes=%0d", words, strobes);
  endtask

  task automatic test_abort();
    int found;
    salt0 = $urandom;
    ready0 = 1'b1;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    found = 0;
    for (int c = 0; c < 400 && found == 0; c++) begin
      ready0 = (sel0 != 7'h2A);
      if (valid0 && sel0 == 7'h2A) found = 1;
      else begin @(posedge clk); #1; end
    end
    n_tests++;
    if (found == 0) begin
      n_fail++;
      $display("FAIL abort_reach: got no EMIT of data word 10 want reached within 400 cycles");
    end
    abort0 = 1'b1;
    ready0 = 1'b0;
    @(posedge clk); #1;
    abort0 = 1'b0;
    n_tests++;
    if (valid0 || busy0 || rden0 || done0) begin
      n_fail++;
      $display("FAIL abort_outputs: got valid=%b busy=%b rden=%b done=%b want all 0",
               valid0, busy0, rden0, done0);
    end
    n_tests++;
    if (data0 !== muxval(7'h2A, salt0)) begin
      n_fail++;
      $display("FAIL abort_data_hold: got %h want %h", data0, muxval(7'h2A, salt0));
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      n_tests++;
      if (done0 || busy0) begin
        n_fail++;
        $display("FAIL abort_quiet%0d: got done=%b busy=%b want 0 0", k, done0, busy0);
      end
    end
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    n_tests++;
    if (!(rden0 && busy0 && sel0 == 7'h00)) begin
      n_fail++;
      $display("FAIL abort_restart: got rden=%b busy=%b sel=%h want 1 1 00", rden0, busy0, sel0);
    end
    abort0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b1;
    abort0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    abort0 = 1'b0;
    n_tests++;
    if (busy0 || rden0) begin
      n_fail++;
      $display("FAIL abort_start_idle: got busy=%b rden=%b want 0 0", busy0, rden0);
    end
    $display("[TB] abort: dropped data word 10, restart and abort-over-start checked");
  endtask

  task automatic test_start_ignored();
    int words, dones;
    salt0 = $urandom;
    ready0 = 1'b1;
    words = 0; dones = 0;
    start0 = 1'b1;
    @(posedge clk); #1;
    for (int cyc = 1; cyc < 3000 && dones == 0; cyc++) begin
      ready0 = ($urandom_range(3) != 0);
      start0 = ($urandom_range(7) == 0);
      abort0 = 1'b0;
      if (valid0 && ready0) begin
        n_tests++;
        if (data0 !== muxval(sel0, salt0) ||
            sel0 !== ((words < 32) ? 7'(words) : (words < 64) ? 7'(words) : 7'h40)) begin
          n_fail++;
          $display("FAIL ignore_word%0d: got sel=%h data=%h want in-order word %0d",
                   words, sel0, data0, words);
        end
        words++;
      end
      if (done0) begin
        dones++;
        start0 = 1'b1;
        abort0 = 1'b1;
      end
      @(posedge clk); #1;
    end
    start0 = 1'b0;
    abort0 = 1'b0;
    n_tests++;
    if (dones != 1 || words != 65) begin
      n_fail++;
      $display("FAIL ignore_counts: got done=%0d words=%0d want 1 65", dones, words);
    end
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (busy0 || rden0 || done0) begin
        n_fail++;
        $display("FAIL ignore_not_queued%0d: got busy=%b rden=%b done=%b want 0 0 0",
                 k, busy0, rden0, done0);
      end
      @(posedge clk); #1;
    end
    $display("[TB] start_ignored: words=%0d with random start pulses while busy", words);
  endtask

  initial begin
    rstn   = 1'b0;
    start0 = 1'b0; abort0 = 1'b0; ready0 = 1'b0;
    start1 = 1'b0; abort1 = 1'b0; ready1 = 1'b0;
    test_reset();
    test_full_dump(100, 32'd0);
    test_full_dump(60, $urandom);
    test_backpressure();
    test_small_config();
    test_abort();
    test_start_ignored();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running want finished by 500000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dbgdump.md
# dbgdump

Debug dump sequencer that walks the core's debug read mux and streams a full state snapshot out over a valid/ready word interface. On a `start` pulse it reads every general-purpose register, then every debug-visible data word, then the PC. Each read is a debug-select/read-enable cycle followed by a fixed read latency, and each result is emitted as one 32-bit word. It sits between the debug select mux and the host-facing debug transport (UART/serializer), so that transport never drives the select lines directly.

## Interface
- `NREGS`, default 32: number of registers dumped, 1..32; indices 0..NREGS-1.
- `NDATA`, default 32: number of data words dumped, 0..32; indices 0..NDATA-1.
- `RDLAT`, default 1: cycles from the read-enable cycle to a valid `dbgin`, 1..4.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rstn`  in  1: asynchronous, active-low reset.
- `start`  in  1: pulse; begins a dump when IDLE, ignored otherwise.
- `abort`  in  1: synchronous abandon of a dump in progress.
- `dbgsel`  out  7: select to the debug mux.
- `dbgreaden`  out  1: read strobe to the debug mux.
- `dbgin`  in  32: mux output, valid RDLAT cycles after the read strobe.
- `out_data`  out  32: emitted word.
- `out_valid`  out  1: `out_data` valid.
- `out_ready`  in  1: consumer accepts the word.
- `busy`  out  1: a dump is in progress.
- `done`  out  1: one-cycle pulse when a dump completes normally.

## Operation
- Select encoding:
  - register i: `dbgsel` = {2'b00, i[4:0]}.
  - data word j: `dbgsel` = {2'b01, j[4:0]}.
  - PC: `dbgsel` = 7'b1000000.
- Dump order is fixed: reg 0..NREGS-1, data 0..NDATA-1, PC. That is NREGS+NDATA+1 words per dump (65 at defaults). When NDATA=0 the data phase is skipped.
- States:
  - IDLE: `busy`=0. `start` moves to SEL with phase=REG and idx=0.
  - SEL: drive `dbgsel` for the current item and `dbgreaden`=1 for exactly this cycle. Load the wait counter with RDLAT. Go to WAIT.
  - WAIT: `dbgsel` held and `dbgreaden`=0. Decrement the counter. When it reaches 0, capture `dbgin` into `out_data` and go to EMIT.
  - EMIT: `out_valid`=1, with `out_data` and `dbgsel` held stable until `out_ready`. On the handshake:
    - If the item was the PC, go to DONE.
    - Otherwise advance: idx+1 within the phase. At the last index, move REG→DATA (or →PC if NDATA=0), or DATA→PC, with idx=0. Go to SEL.
  - DONE: `done`=1 for one cycle, `busy`=0 next. Return to IDLE.
- `busy` = 1 in SEL, WAIT and EMIT.
- The index counter is 5 bits and never wraps. Phase transitions occur at NREGS-1 and NDATA-1 exactly.
- `abort` in SEL, WAIT or EMIT goes to IDLE on the next edge:
  - `out_valid`, `dbgreaden` and `busy` are 0 next cycle.
  - `done` is not pulsed.
  - A word being offered is dropped even without a handshake.
- `abort` and `start` asserted together while IDLE: `abort` wins and the block stays IDLE.
- `abort` in IDLE or DONE has no effect; DONE still returns to IDLE.
- `start` while busy or in DONE is ignored; it is not queued.

## Timing
- Reset (`rstn`=0, asynchronous) forces IDLE immediately, including mid-dump. Output values during reset:
  - `dbgsel`=0, `dbgreaden`=0.
  - `out_data`=0, `out_valid`=0.
  - `busy`=0, `done`=0.
- `start` sampled at edge t puts SEL (`dbgreaden`=1) in cycle t+1.
- `dbgin` is sampled at the edge ending the RDLAT-th WAIT cycle, so `out_valid` rises RDLAT+1 cycles after the SEL cycle.
- Per-word minimum is RDLAT+2 cycles with `out_ready` held at 1.
- Minimum dump length at defaults (RDLAT=1, 65 words): 1 + 65×3 = 196 cycles from the `start` edge to the `done` cycle inclusive.
- `out_ready` may be high before `out_valid`; the handshake counts only in EMIT.
- `out_data` keeps its last value when `out_valid`=0.
- All outputs are registered; no combinational path exists from `out_ready` or `dbgin` to any output.

## Test plan
- Reset mid-dump: assert `rstn`=0 in WAIT of data word 5. All outputs go to 0 without waiting for a clock edge. After release, `start` begins again at reg 0 (`dbgsel`=7'h00).
- Full dump, defaults, `out_ready`=1, model returns `dbgin`=`dbgsel`×3:
  - 65 words in order: 0x0..0x5D for regs 0..31 (`dbgsel` 0x00..0x1F), 0x60..0xBD for data 0..31 (`dbgsel` 0x20..0x3F), then 0xC0 for the PC.
  - `done` pulses once, at cycle 196.
- Backpressure: `out_ready` low for 7 cycles on reg 3. `out_valid`, `out_data` and `dbgsel`=7'h03 are stable throughout, and no extra `dbgreaden` strobes occur.
- NREGS=4, NDATA=0, RDLAT=3: `dbgsel` sequence is 00, 01, 02, 03, 40. There are 5 cycles from each SEL to its handshake, and `dbgreaden` is high for exactly one cycle per word.
- Abort in EMIT of data word 10 with `out_ready`=0: `out_valid`=0 next cycle and no `done`. A following `start` restarts at reg 0, and `start` pulses while busy are ignored.
